// File: rtl/gcd_ctrl_if.sv
// rtl/gcd_ctrl_if.sv - request/result bundle between a GCD requester and the gcd_ctrl engine
interface gcd_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] gcd_out;
   logic [WIDTH-1:0] iter_cnt;
   logic             zero_in;

   modport master (
      output start, a_in, b_in,
      input  ready, busy, done, gcd_out, iter_cnt, zero_in
   );

   modport slave (
      input  start, a_in, b_in,
      output ready, busy, done, gcd_out, iter_cnt, zero_in
   );
endinterface

// File: rtl/gcd_ctrl.sv
// rtl/gcd_ctrl.sv - iterative subtractive GCD engine, one compare/subtract step per clock
module gcd_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   gcd_ctrl_if.slave  bus
);
   // One-hot encoding lets ready/busy/done come straight off single flops.
   typedef enum logic [2:0] {
      IDLE = 3'b001,
      RUN  = 3'b010,
      DONE = 3'b100
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] gcd_q;
   logic [WIDTH-1:0] iter_q;
   logic             zero_q;

   logic             a_gt_b;
   logic             a_eq_b;
   logic [WIDTH-1:0] diff;

   // Compare/subtract unit: the difference is always larger minus smaller, so no borrow.
   assign a_gt_b = ra > rb;
   assign a_eq_b = ra == rb;
   assign diff   = a_gt_b ? (ra - rb) : (rb - ra);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ra     <= '0;
         rb     <= '0;
         gcd_q  <= '0;
         iter_q <= '0;
         zero_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  ra     <= bus.a_in;
                  rb     <= bus.b_in;
                  iter_q <= '0;
                  zero_q <= 1'b0;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (ra == '0 || rb == '0) begin
                  gcd_q  <= ra | rb;
                  zero_q <= (ra == '0) && (rb == '0);
                  state  <= DONE;
               end else if (a_eq_b) begin
                  gcd_q <= ra;
                  state <= DONE;
               end else if (a_gt_b) begin
                  ra     <= diff;
                  iter_q <= iter_q + WIDTH'(1);
               end else begin
                  rb     <= diff;
                  iter_q <= iter_q + WIDTH'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.ready    = state[0];
   assign bus.busy     = state[1];
   assign bus.done     = state[2];
   assign bus.gcd_out  = gcd_q;
   assign bus.iter_cnt = iter_q;
   assign bus.zero_in  = zero_q;
endmodule

// File: tb/tb_gcd_ctrl.sv
// tb/tb_gcd_ctrl.sv - self-checking bench for gcd_ctrl against a Euclid-based timeline model
module tb_gcd_ctrl;
   localparam int WIDTH = 4;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   gcd_ctrl_if #(.WIDTH(WIDTH)) bus ();

   gcd_ctrl #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int g;
      int n;
      int z;
   } job_t;

   // Result via Euclid with division; the subtraction count is the sum of quotients minus the final equal step.
   function automatic job_t gcd_ref(int a, int b);
      job_t r;
      int x, y, t, q;
      r.z = (a == 0 && b == 0) ? 1 : 0;
      if (a == 0 || b == 0) begin
         r.g = a | b;
         r.n = 0;
         return r;
      end
      x = (a > b) ? a : b;
      y = (a > b) ? b : a;
      q = 0;
      while (y != 0) begin
         q = q + x / y;
         t = x % y;
         x = y;
         y = t;
      end
      r.g = x;
      r.n = q - 1;
      return r;
   endfunction

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Timeline model: phase 0 idle, 1 running, 2 done.
   int   m_valid;
   int   m_phase;
   int   m_step;
   int   m_gcd;
   int   m_iter;
   int   m_zero;
   job_t m_job;

   initial begin
      m_valid = 0;
      m_phase = 0;
      m_step  = 0;
      m_gcd   = 0;
      m_iter  = 0;
      m_zero  = 0;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1;
         m_phase = 0;
         m_gcd   = 0;
         m_iter  = 0;
         m_zero  = 0;
      end else if (m_valid == 1) begin
         if (m_phase == 0) begin
            if (bus.start) begin
               m_job   = gcd_ref(int'(bus.a_in), int'(bus.b_in));
               m_step  = 0;
               m_iter  = 0;
               m_zero  = 0;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (m_step == m_job.n) begin
               m_gcd   = m_job.g;
               m_zero  = m_job.z;
               m_phase = 2;
            end else begin
               m_step = m_step + 1;
               m_iter = m_step;
            end
         end else begin
            m_phase = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid == 1) begin
         chk("ready",    int'(bus.ready),    (m_phase == 0) ? 1 : 0);
         chk("busy",     int'(bus.busy),     (m_phase == 1) ? 1 : 0);
         chk("done",     int'(bus.done),     (m_phase == 2) ? 1 : 0);
         chk("gcd_out",  int'(bus.gcd_out),  m_gcd);
         chk("iter_cnt", int'(bus.iter_cnt), m_iter);
         chk("zero_in",  int'(bus.zero_in),  m_zero);
      end
   end

   task automatic wait_done(output int cyc, output int bcnt);
      cyc  = 0;
      bcnt = 0;
      while (!bus.done && cyc < 40) begin
         if (bus.busy) bcnt++;
         @(negedge clk);
         cyc++;
      end
      chk("done_seen", int'(bus.done), 1);
   endtask

   task automatic run_job(int a, int b, int eg, int en, int ez);
      int cyc, bcnt;
      bus.start = 1'b1;
      bus.a_in  = WIDTH'(a);
      bus.b_in  = WIDTH'(b);
      @(negedge clk);
      bus.start = 1'b0;
      bus.a_in  = '1;
      bus.b_in  = '1;
      wait_done(cyc, bcnt);
      chk("latency",    cyc,                en + 1);
      chk("busy_cycles", bcnt,              en + 1);
      chk("job_gcd",    int'(bus.gcd_out),  eg);
      chk("job_iter",   int'(bus.iter_cnt), en);
      chk("job_zero",   int'(bus.zero_in),  ez);
      @(negedge clk);
      chk("ready_after", int'(bus.ready), 1);
   endtask

   initial begin
      job_t r;
      int   cyc, bcnt;
      total = 0;
      bad   = 0;
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.a_in  = 4'd3;
      bus.b_in  = 4'd5;
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      rst       = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);

      r = gcd_ref(12, 8);  chk("ref_12_8_g", r.g, 4);  chk("ref_12_8_n", r.n, 2);
      r = gcd_ref(15, 1);  chk("ref_15_1_n", r.n, 14);
      r = gcd_ref(1, 15);  chk("ref_1_15_g", r.g, 1);
      r = gcd_ref(0, 0);   chk("ref_0_0_z", r.z, 1);

      run_job(12, 8, 4, 2, 0);
      run_job(15, 1, 1, 14, 0);
      run_job(1, 15, 1, 14, 0);
      run_job(6, 6, 6, 0, 0);
      run_job(0, 9, 9, 0, 0);
      run_job(0, 0, 0, 0, 1);

      // A start pulse during RUN must be dropped.
      bus.start = 1'b1;
      bus.a_in  = 4'd9;
      bus.b_in  = 4'd6;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a_in  = 4'd5;
      bus.b_in  = 4'd5;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(cyc, bcnt);
      chk("ign_gcd",  int'(bus.gcd_out),  3);
      chk("ign_iter", int'(bus.iter_cnt), 2);
      repeat (3) @(negedge clk);

      // Reset sampled at edge 5 of a worst-case job.
      bus.start = 1'b1;
      bus.a_in  = 4'd15;
      bus.b_in  = 4'd1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ready", int'(bus.ready),    1);
      chk("abort_iter",  int'(bus.iter_cnt), 0);
      chk("abort_done",  int'(bus.done),     0);
      rst = 1'b0;
      @(negedge clk);
      run_job(10, 4, 2, 3, 0);

      // Start held high: back-to-back jobs accepted as soon as ready returns.
      bus.start = 1'b1;
      bus.a_in  = 4'd12;
      bus.b_in  = 4'd8;
      repeat (12) @(negedge clk);
      bus.start = 1'b0;
      repeat (8) @(negedge clk);
      chk("final_ready", int'(bus.ready), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end
endmodule
